// File: rtl/color_selector.sv
// ---------------------------------------------------------------------------
// color_selector
//
// Upstream stage of the text display top level. Two raw pushbuttons
// (next / previous) are synchronised, debounced and edge-detected; each
// debounced press steps a 3-bit colour index with wrap-around. The index is
// decoded into eight registered, mutually exclusive colour select lines that
// feed the character pixel generator. Runs on the system clock.
//
// Parameters:
//   DB_CYCLES   - clk cycles a synchronised level must differ from the
//                 debounced state before that state flips (2 .. 2^24)
//   RESET_COLOR - colour index loaded at reset (7 = White)
//
// Ports:
//   clk           in   system clock, all state on rising edge
//   reset         in   asynchronous active-high reset of every register
//   btn_next      in   raw bouncing button, press = 1, steps index +1
//   btn_prev      in   raw bouncing button, press = 1, steps index -1
//   Black..White  out  registered one-hot colour select (index 0..7)
//   color_idx     out  registered current index, {R,G,B}
//   color_changed out  one-cycle pulse in the cycle the selects take a new value
// ---------------------------------------------------------------------------
module color_selector #(
    parameter int         DB_CYCLES   = 1000000,
    parameter logic [2:0] RESET_COLOR = 3'd7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       btn_prev,
    output logic       Black,
    output logic       Blue,
    output logic       Green,
    output logic       Cyan,
    output logic       Red,
    output logic       Magenta,
    output logic       Yellow,
    output logic       White,
    output logic [2:0] color_idx,
    output logic       color_changed
);

    localparam int             CW      = $clog2(DB_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

    // Channel 0 = next, channel 1 = prev.
    logic [1:0]    raw;
    logic [1:0]    sync1_p0;
    logic [1:0]    sync2_p1;
    logic [1:0]    stable_p2;
    logic [1:0]    stable_d_p3;
    logic [CW-1:0] cnt_p2 [2];
    logic [1:0]    press_p2;

    logic [2:0]    idx_p3;
    logic [7:0]    sel_p4;

    function automatic logic [7:0] decode(input logic [2:0] i);
        decode = 8'd1 << i;
    endfunction

    assign raw = {btn_prev, btn_next};

    // ---- stage 0/1: two-flop synchroniser per button ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_p0 <= 2'b00;
            sync2_p1 <= 2'b00;
        end else begin
            sync1_p0 <= raw;
            sync2_p1 <= sync1_p0;
        end
    end

    // ---- stage 2: debounce, counter restarts whenever the level returns
    //      to the stable value before the full count completes ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_p2 <= 2'b00;
            cnt_p2[0] <= '0;
            cnt_p2[1] <= '0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (sync2_p1[ch] == stable_p2[ch]) begin
                    cnt_p2[ch] <= '0;
                end else if (cnt_p2[ch] == CNT_MAX) begin
                    stable_p2[ch] <= sync2_p1[ch];
                    cnt_p2[ch]    <= '0;
                end else begin
                    cnt_p2[ch] <= cnt_p2[ch] + 1'b1;
                end
            end
        end
    end

    // ---- stage 3: edge detect and index update ----
    // Rising edge of the debounced level only, so a held button never repeats.
    assign press_p2 = stable_p2 & ~stable_d_p3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_d_p3 <= 2'b00;
            idx_p3      <= RESET_COLOR;
        end else begin
            stable_d_p3 <= stable_p2;
            // Both pressed in the same cycle cancel out.
            if (press_p2[0] && !press_p2[1]) begin
                idx_p3 <= idx_p3 + 3'd1;
            end else if (press_p2[1] && !press_p2[0]) begin
                idx_p3 <= idx_p3 - 3'd1;
            end
        end
    end

    // ---- stage 4: registered decode and change pulse ----
    // color_idx still holds the previous index here, so a mismatch means
    // idx_p3 moved on the last edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_p4        <= decode(RESET_COLOR);
            color_idx     <= RESET_COLOR;
            color_changed <= 1'b0;
        end else begin
            sel_p4        <= decode(idx_p3);
            color_idx     <= idx_p3;
            color_changed <= (idx_p3 != color_idx);
        end
    end

    assign Black   = sel_p4[0];
    assign Blue    = sel_p4[1];
    assign Green   = sel_p4[2];
    assign Cyan    = sel_p4[3];
    assign Red     = sel_p4[4];
    assign Magenta = sel_p4[5];
    assign Yellow  = sel_p4[6];
    assign White   = sel_p4[7];

endmodule

// File: tb/tb_color_selector.sv
// ---------------------------------------------------------------------------
// tb_color_selector
//
// Directed bench for color_selector with DB_CYCLES = 4. A raw level applied
// before edge k appears on the outputs after edge k+7.
// ---------------------------------------------------------------------------
module tb_color_selector;

    logic       clk;
    logic       reset;
    logic       btn_next;
    logic       btn_prev;
    logic       Black, Blue, Green, Cyan, Red, Magenta, Yellow, White;
    logic [2:0] color_idx;
    logic       color_changed;
    logic [7:0] obs;

    int vectors;
    int miscompares;

    assign obs = {White, Yellow, Magenta, Red, Cyan, Green, Blue, Black};

    color_selector #(
        .DB_CYCLES  (4),
        .RESET_COLOR(3'd7)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_next     (btn_next),
        .btn_prev     (btn_prev),
        .Black        (Black),
        .Blue         (Blue),
        .Green        (Green),
        .Cyan         (Cyan),
        .Red          (Red),
        .Magenta      (Magenta),
        .Yellow       (Yellow),
        .White        (White),
        .color_idx    (color_idx),
        .color_changed(color_changed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle past it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Hold the given buttons 10 cycles, release 10 cycles; report how many
    // change pulses were seen and whether the selects always matched color_idx
    // with exactly one line high.
    task automatic press_window(input bit nxt, input bit prv,
                                output int pulses, output bit onehot_ok);
        logic [7:0] want;
        pulses    = 0;
        onehot_ok = 1'b1;
        btn_next  = nxt;
        btn_prev  = prv;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                btn_next = 1'b0;
                btn_prev = 1'b0;
            end
            cyc();
            if (color_changed === 1'b1) pulses++;
            case (color_idx)
                3'd0: want = 8'b0000_0001;
                3'd1: want = 8'b0000_0010;
                3'd2: want = 8'b0000_0100;
                3'd3: want = 8'b0000_1000;
                3'd4: want = 8'b0001_0000;
                3'd5: want = 8'b0010_0000;
                3'd6: want = 8'b0100_0000;
                3'd7: want = 8'b1000_0000;
                default: want = 8'hxx;
            endcase
            if (obs !== want) onehot_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        #12;
        reset = 1'b1;
        #1;
        vectors++;
        if (obs !== 8'h80) begin
            miscompares++;
            $display("FAIL reset_onehot: got %b, expected %b", obs, 8'h80);
        end
        vectors++;
        if (color_idx !== 3'd7) begin
            miscompares++;
            $display("FAIL reset_idx: got %0d, expected 7", color_idx);
        end
        vectors++;
        if (color_changed !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_changed: got %b, expected 0", color_changed);
        end
        repeat (2) cyc();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            vectors++;
            if (obs !== 8'h80 || color_idx !== 3'd7 || color_changed !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d: got sel=%b idx=%0d chg=%b, expected sel=10000000 idx=7 chg=0",
                         i, obs, color_idx, color_changed);
            end
        end
    endtask

    task automatic test_single_press();
        @(negedge clk);
        btn_next = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            vectors++;
            if (i < 7) begin
                if (color_idx !== 3'd7 || obs !== 8'h80 || color_changed !== 1'b0) begin
                    miscompares++;
                    $display("FAIL single_early edge k+%0d: got idx=%0d sel=%b chg=%b, expected idx=7 sel=10000000 chg=0",
                             i, color_idx, obs, color_changed);
                end
            end else if (i == 7) begin
                if (color_idx !== 3'd0 || obs !== 8'h01 || color_changed !== 1'b1) begin
                    miscompares++;
                    $display("FAIL single_wrap edge k+7: got idx=%0d sel=%b chg=%b, expected idx=0 sel=00000001 chg=1",
                             color_idx, obs, color_changed);
                end
            end else begin
                if (color_idx !== 3'd0 || color_changed !== 1'b0) begin
                    miscompares++;
                    $display("FAIL single_hold edge k+%0d: got idx=%0d chg=%b, expected idx=0 chg=0",
                             i, color_idx, color_changed);
                end
            end
        end
        btn_next = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cyc();
            vectors++;
            if (color_idx !== 3'd0 || obs !== 8'h01 || color_changed !== 1'b0) begin
                miscompares++;
                $display("FAIL single_release cycle %0d: got idx=%0d sel=%b chg=%b, expected idx=0 sel=00000001 chg=0",
                         i, color_idx, obs, color_changed);
            end
        end
    endtask

    task automatic test_bounce();
        for (int t = 0; t < 4; t++) begin
            btn_prev = (t % 2 == 0);
            repeat (2) begin
                cyc();
                vectors++;
                if (color_idx !== 3'd0 || color_changed !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bounce_toggle phase %0d: got idx=%0d chg=%b, expected idx=0 chg=0",
                             t, color_idx, color_changed);
                end
            end
        end
        btn_prev = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            vectors++;
            if (i < 7) begin
                if (color_idx !== 3'd0 || color_changed !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bounce_early edge k+%0d: got idx=%0d chg=%b, expected idx=0 chg=0",
                             i, color_idx, color_changed);
                end
            end else if (i == 7) begin
                if (color_idx !== 3'd7 || obs !== 8'h80 || color_changed !== 1'b1) begin
                    miscompares++;
                    $display("FAIL bounce_step edge k+7: got idx=%0d sel=%b chg=%b, expected idx=7 sel=10000000 chg=1",
                             color_idx, obs, color_changed);
                end
            end else begin
                if (color_idx !== 3'd7 || color_changed !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bounce_hold edge k+%0d: got idx=%0d chg=%b, expected idx=7 chg=0",
                             i, color_idx, color_changed);
                end
            end
        end
        btn_prev = 1'b0;
        repeat (12) cyc();
    endtask

    task automatic test_walk();
        int         pulses;
        bit         ok;
        logic [2:0] exp_idx;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        repeat (2) cyc();
        exp_idx = 3'd7;
        for (int p = 0; p < 8; p++) begin
            press_window(1'b1, 1'b0, pulses, ok);
            exp_idx = exp_idx + 3'd1;
            vectors++;
            if (color_idx !== exp_idx || pulses != 1 || !ok) begin
                miscompares++;
                $display("FAIL walk_next press %0d: got idx=%0d pulses=%0d onehot_ok=%0d, expected idx=%0d pulses=1 onehot_ok=1",
                         p, color_idx, pulses, ok, exp_idx);
            end
        end
        for (int p = 0; p < 9; p++) begin
            press_window(1'b0, 1'b1, pulses, ok);
            exp_idx = exp_idx - 3'd1;
            vectors++;
            if (color_idx !== exp_idx || pulses != 1 || !ok) begin
                miscompares++;
                $display("FAIL walk_prev press %0d: got idx=%0d pulses=%0d onehot_ok=%0d, expected idx=%0d pulses=1 onehot_ok=1",
                         p, color_idx, pulses, ok, exp_idx);
            end
        end
    endtask

    task automatic test_simultaneous();
        btn_next = 1'b1;
        btn_prev = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 12) begin
                btn_next = 1'b0;
                btn_prev = 1'b0;
            end
            cyc();
            vectors++;
            if (color_idx !== 3'd6 || obs !== 8'h40 || color_changed !== 1'b0) begin
                miscompares++;
                $display("FAIL simultaneous cycle %0d: got idx=%0d sel=%b chg=%b, expected idx=6 sel=01000000 chg=0",
                         i, color_idx, obs, color_changed);
            end
        end
    endtask

    task automatic test_back_to_back();
        btn_next = 1'b1;
        cyc();
        btn_prev = 1'b1;
        for (int i = 1; i < 10; i++) begin
            cyc();
            vectors++;
            if (i < 7) begin
                if (color_idx !== 3'd6 || color_changed !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_early edge k+%0d: got idx=%0d chg=%b, expected idx=6 chg=0",
                             i, color_idx, color_changed);
                end
            end else if (i == 7) begin
                if (color_idx !== 3'd7 || obs !== 8'h80 || color_changed !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_first edge k+7: got idx=%0d sel=%b chg=%b, expected idx=7 sel=10000000 chg=1",
                             color_idx, obs, color_changed);
                end
            end else if (i == 8) begin
                if (color_idx !== 3'd6 || obs !== 8'h40 || color_changed !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_second edge k+8: got idx=%0d sel=%b chg=%b, expected idx=6 sel=01000000 chg=1",
                             color_idx, obs, color_changed);
                end
            end else begin
                if (color_idx !== 3'd6 || color_changed !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_after edge k+9: got idx=%0d chg=%b, expected idx=6 chg=0",
                             color_idx, color_changed);
                end
            end
        end
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (12) cyc();
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        repeat (2) cyc();
        btn_next = 1'b1;
        repeat (4) cyc();
        reset = 1'b1;
        #1;
        vectors++;
        if (color_idx !== 3'd7 || obs !== 8'h80 || color_changed !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_assert: got idx=%0d sel=%b chg=%b, expected idx=7 sel=10000000 chg=0",
                     color_idx, obs, color_changed);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            vectors++;
            if (i < 7) begin
                if (color_idx !== 3'd7 || color_changed !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_mid_early edge k+%0d: got idx=%0d chg=%b, expected idx=7 chg=0",
                             i, color_idx, color_changed);
                end
            end else if (i == 7) begin
                if (color_idx !== 3'd0 || obs !== 8'h01 || color_changed !== 1'b1) begin
                    miscompares++;
                    $display("FAIL reset_mid_step edge k+7: got idx=%0d sel=%b chg=%b, expected idx=0 sel=00000001 chg=1",
                             color_idx, obs, color_changed);
                end
            end else begin
                if (color_idx !== 3'd0 || color_changed !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_mid_hold edge k+%0d: got idx=%0d chg=%b, expected idx=0 chg=0",
                             i, color_idx, color_changed);
                end
            end
        end
        btn_next = 1'b0;
        repeat (10) cyc();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_press();
        test_bounce();
        test_walk();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
